// File: rtl/hawk_pkg.sv
// hawk_pkg
// Shared definitions for the Hawk read path: the deserializer state
// encoding and the default framing constants.
package hawk_pkg;

   typedef enum logic [1:0] {
      SD_IDLE = 2'd0,
      SD_HUNT = 2'd1,
      SD_DATA = 2'd2
   } sd_state_t;

   localparam int unsigned HAWK_PREAMBLE_MIN = 16;
   localparam int unsigned HAWK_WORD_WIDTH   = 16;
   localparam int unsigned HAWK_SECTOR_WORDS = 256;
   localparam int unsigned HAWK_BIT_TIMEOUT  = 64;

endpackage

// File: rtl/hawk_word_buffer.sv
// hawk_word_buffer
// One-entry valid/ready holding register. A new entry is accepted when the
// register is empty or is being drained in the same cycle; otherwise the
// new entry is dropped and overrun pulses for that cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous clear of the held entry
//   in_valid   : in_data is offered this cycle
//   in_data    : entry to store
//   out_valid  : register holds an entry
//   out_data   : held entry, stable while out_valid=1
//   out_ready  : consumer takes the entry (transfer on out_valid & out_ready)
//   overrun    : one-cycle pulse when an offered entry is dropped
module hawk_word_buffer #(
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          overrun
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      overrun = 1'b0;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (in_valid) begin
         if (!valid_q || out_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
         end else begin
            overrun = 1'b1;
         end
      end
      if (flush) begin
         valid_d = 1'b0;
         data_d  = '0;
         overrun = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/sector_deserializer.sv
// sector_deserializer
// Hunts the separated bit stream for the sector preamble and sync bit, then
// assembles data bits MSB-first into words delivered through a one-entry
// valid/ready buffer. Flags sector boundaries, overruns and lost clocks.
// Ports:
//   hf_clk, rst    : sole clock, synchronous active-high reset
//   en             : block enable; low returns to IDLE and flushes the buffer
//   bit_clock      : one-cycle strobe per bit cell
//   bit_data       : bit value, valid with bit_clock
//   word_out       : assembled word, stable while word_valid=1
//   word_valid     : buffer holds a word
//   word_ready     : consumer accepts the word
//   word_index     : index of the word on word_out within its sector
//   sector_start   : pulse, cycle after the sync strobe
//   sector_done    : pulse, coincident with the last word becoming valid
//   overrun        : sticky, a completed word was dropped
//   lost_clock     : sticky, DATA aborted by bit timeout
module sector_deserializer
   import hawk_pkg::*;
#(
   parameter int unsigned PREAMBLE_MIN = HAWK_PREAMBLE_MIN,
   parameter int unsigned WORD_WIDTH   = HAWK_WORD_WIDTH,
   parameter int unsigned SECTOR_WORDS = HAWK_SECTOR_WORDS,
   parameter int unsigned BIT_TIMEOUT  = HAWK_BIT_TIMEOUT
) (
   input  logic                            hf_clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            bit_clock,
   input  logic                            bit_data,
   output logic [WORD_WIDTH-1:0]           word_out,
   output logic                            word_valid,
   input  logic                            word_ready,
   output logic [$clog2(SECTOR_WORDS)-1:0] word_index,
   output logic                            sector_start,
   output logic                            sector_done,
   output logic                            overrun,
   output logic                            lost_clock
);

   localparam int unsigned ZW = $clog2(PREAMBLE_MIN + 1);
   localparam int unsigned BW = $clog2(WORD_WIDTH);
   localparam int unsigned IW = $clog2(SECTOR_WORDS);
   localparam int unsigned TW = $clog2(BIT_TIMEOUT) + 1;

   sd_state_t             state_q, state_d;
   logic [ZW-1:0]         zero_cnt_q, zero_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [IW-1:0]         word_cnt_q, word_cnt_d;
   logic [TW-1:0]         idle_cnt_q, idle_cnt_d;
   logic [WORD_WIDTH-1:0] shift_q, shift_d;
   logic                  sector_start_q, sector_start_d;
   logic                  sector_done_q, sector_done_d;
   logic                  overrun_q, overrun_d;
   logic                  lost_clock_q, lost_clock_d;

   logic                  word_done;
   logic [WORD_WIDTH-1:0] done_word;
   logic                  buf_overrun;
   logic [IW+WORD_WIDTH-1:0] buf_data;

   // The completing bit is merged combinationally so the word reaches the
   // buffer on the same edge that samples its last strobe.
   assign done_word = {shift_q[WORD_WIDTH-2:0], bit_data};

   always_comb begin
      state_d        = state_q;
      zero_cnt_d     = zero_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      word_cnt_d     = word_cnt_q;
      idle_cnt_d     = idle_cnt_q;
      shift_d        = shift_q;
      sector_start_d = 1'b0;
      sector_done_d  = 1'b0;
      overrun_d      = overrun_q | buf_overrun;
      lost_clock_d   = lost_clock_q;
      word_done      = 1'b0;

      if (!en || state_q == SD_IDLE) begin
         zero_cnt_d = '0;
         bit_cnt_d  = '0;
         word_cnt_d = '0;
         idle_cnt_d = '0;
         shift_d    = '0;
         state_d    = en ? SD_HUNT : SD_IDLE;
      end else if (state_q == SD_HUNT) begin
         if (bit_clock) begin
            if (!bit_data) begin
               if (zero_cnt_q < ZW'(PREAMBLE_MIN)) begin
                  zero_cnt_d = zero_cnt_q + 1'b1;
               end
            end else if (zero_cnt_q == ZW'(PREAMBLE_MIN)) begin
               sector_start_d = 1'b1;
               overrun_d      = 1'b0;
               lost_clock_d   = 1'b0;
               bit_cnt_d      = '0;
               word_cnt_d     = '0;
               idle_cnt_d     = '0;
               shift_d        = '0;
               state_d        = SD_DATA;
            end else begin
               zero_cnt_d = '0;
            end
         end
      end else begin
         if (bit_clock) begin
            idle_cnt_d = '0;
            shift_d    = done_word;
            if (bit_cnt_q == BW'(WORD_WIDTH - 1)) begin
               bit_cnt_d  = '0;
               word_done  = 1'b1;
               word_cnt_d = word_cnt_q + 1'b1;
               if (word_cnt_q == IW'(SECTOR_WORDS - 1)) begin
                  sector_done_d = 1'b1;
                  zero_cnt_d    = '0;
                  state_d       = SD_HUNT;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end else if (idle_cnt_q >= TW'(BIT_TIMEOUT)) begin
            lost_clock_d = 1'b1;
            bit_cnt_d    = '0;
            shift_d      = '0;
            zero_cnt_d   = '0;
            state_d      = SD_HUNT;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge hf_clk) begin
      if (rst) begin
         state_q        <= SD_IDLE;
         zero_cnt_q     <= '0;
         bit_cnt_q      <= '0;
         word_cnt_q     <= '0;
         idle_cnt_q     <= '0;
         shift_q        <= '0;
         sector_start_q <= 1'b0;
         sector_done_q  <= 1'b0;
         overrun_q      <= 1'b0;
         lost_clock_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         zero_cnt_q     <= zero_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         word_cnt_q     <= word_cnt_d;
         idle_cnt_q     <= idle_cnt_d;
         shift_q        <= shift_d;
         sector_start_q <= sector_start_d;
         sector_done_q  <= sector_done_d;
         overrun_q      <= overrun_d;
         lost_clock_q   <= lost_clock_d;
      end
   end

   hawk_word_buffer #(
      .DW(IW + WORD_WIDTH)
   ) u_buf (
      .clk       (hf_clk),
      .rst       (rst),
      .flush     (!en),
      .in_valid  (word_done),
      .in_data   ({word_cnt_q, done_word}),
      .out_valid (word_valid),
      .out_data  (buf_data),
      .out_ready (word_ready),
      .overrun   (buf_overrun)
   );

   assign word_out     = buf_data[WORD_WIDTH-1:0];
   assign word_index   = buf_data[WORD_WIDTH +: IW];
   assign sector_start = sector_start_q;
   assign sector_done  = sector_done_q;
   assign overrun      = overrun_q;
   assign lost_clock   = lost_clock_q;

endmodule

// File: tb/tb_sector_deserializer.sv
module tb_sector_deserializer;
   import hawk_pkg::*;

   logic        hf_clk = 1'b0;
   logic        rst, en, bit_clock, bit_data, word_ready;
   logic [15:0] word_out;
   logic        word_valid;
   logic [7:0]  word_index;
   logic        sector_start, sector_done, overrun, lost_clock;

   typedef struct packed {
      logic [15:0] data;
      logic [7:0]  idx;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0, failures = 0;
   int   start_cnt = 0, done_cnt = 0, xfer_cnt = 0;

   always #5 hf_clk = ~hf_clk;

   sector_deserializer #(
      .PREAMBLE_MIN(16),
      .WORD_WIDTH  (16),
      .SECTOR_WORDS(256),
      .BIT_TIMEOUT (64)
   ) dut (
      .hf_clk      (hf_clk),
      .rst         (rst),
      .en          (en),
      .bit_clock   (bit_clock),
      .bit_data    (bit_data),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .word_index  (word_index),
      .sector_start(sector_start),
      .sector_done (sector_done),
      .overrun     (overrun),
      .lost_clock  (lost_clock)
   );

   // Scoreboard: every valid&ready transfer pops the oldest expected word.
   always @(negedge hf_clk) begin
      if (sector_start) start_cnt++;
      if (sector_done) done_cnt++;
      if (word_valid && word_ready) begin
         xfer_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL xfer_unexpected got word=%h idx=%0d exp=none", word_out, word_index);
         end else begin
            e = exp_q.pop_front();
            if (word_out !== e.data || word_index !== e.idx) begin
               failures++;
               $display("FAIL xfer_word got word=%h idx=%0d exp word=%h idx=%0d",
                        word_out, word_index, e.data, e.idx);
            end
         end
      end
   end

   task automatic tick();
      @(posedge hf_clk);
      #1;
   endtask

   task automatic strobe(input logic b, input int gap);
      bit_clock = 1'b1;
      bit_data  = b;
      tick();
      bit_clock = 1'b0;
      bit_data  = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_word(input logic [15:0] w, input int gap);
      for (int i = 15; i >= 0; i--) strobe(w[i], gap);
   endtask

   task automatic preamble_sync(input int zeros);
      repeat (zeros) strobe(1'b0, 1);
      strobe(1'b1, 1);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; bit_clock = 1'b0; bit_data = 1'b0; word_ready = 1'b0;
      repeat (2) tick();
      checks++; if (word_out !== 16'h0) begin failures++; $display("FAIL reset_word_out got=%h exp=0", word_out); end
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
      checks++; if (word_index !== 8'h0) begin failures++; $display("FAIL reset_word_index got=%0d exp=0", word_index); end
      checks++; if (sector_start !== 1'b0 || sector_done !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", sector_start, sector_done); end
      checks++; if (overrun !== 1'b0 || lost_clock !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b%b exp=00", overrun, lost_clock); end
      checks++; if (dut.state_q !== SD_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, SD_IDLE); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [15:0] w;
      int s;
      w = 16'hA5C3;
      word_ready = 1'b1;
      en = 1'b1;
      tick();
      s = start_cnt;
      repeat (16) strobe(1'b0, 1);
      bit_clock = 1'b1; bit_data = 1'b1;
      tick();
      bit_clock = 1'b0; bit_data = 1'b0;
      checks++; if (sector_start !== 1'b1) begin failures++; $display("FAIL basic_sector_start got=%b exp=1", sector_start); end
      tick();
      for (int i = 15; i >= 1; i--) strobe(w[i], 1);
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", word_valid); end
      exp_q.push_back({w, 8'd0});
      bit_clock = 1'b1; bit_data = w[0];
      tick();
      bit_clock = 1'b0; bit_data = 1'b0;
      checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_latency got=%b exp=1", word_valid); end
      checks++; if (word_out !== 16'hA5C3) begin failures++; $display("FAIL basic_word got=%h exp=a5c3", word_out); end
      checks++; if (word_index !== 8'd0) begin failures++; $display("FAIL basic_index got=%0d exp=0", word_index); end
      repeat (2) tick();
      checks++; if (start_cnt !== s + 1) begin failures++; $display("FAIL basic_start_count got=%0d exp=%0d", start_cnt, s + 1); end
      en = 1'b0;
      tick();
   endtask

   task automatic test_false_sync();
      int s;
      en = 1'b1;
      tick();
      s = start_cnt;
      preamble_sync(10);
      tick();
      checks++; if (start_cnt !== s) begin failures++; $display("FAIL false_sync_start got=%0d exp=%0d", start_cnt, s); end
      checks++; if (dut.state_q !== SD_HUNT) begin failures++; $display("FAIL false_sync_state got=%0d exp=%0d", dut.state_q, SD_HUNT); end
      preamble_sync(20);
      tick();
      checks++; if (start_cnt !== s + 1) begin failures++; $display("FAIL true_sync_start got=%0d exp=%0d", start_cnt, s + 1); end
      checks++; if (dut.state_q !== SD_DATA) begin failures++; $display("FAIL true_sync_state got=%0d exp=%0d", dut.state_q, SD_DATA); end
      en = 1'b0;
      tick();
   endtask

   task automatic test_full_sector();
      logic [7:0]  k;
      logic [15:0] w;
      int x0, d0, s0;
      word_ready = 1'b1;
      en = 1'b1;
      tick();
      preamble_sync(16);
      x0 = xfer_cnt; d0 = done_cnt;
      // Odd words use back-to-back strobes.
      for (int i = 0; i < 255; i++) begin
         k = 8'(i);
         w = {k, ~k};
         exp_q.push_back({w, k});
         send_word(w, (i % 2 == 1) ? 0 : 1);
      end
      w = 16'hFF00;
      exp_q.push_back({w, 8'd255});
      for (int i = 15; i >= 1; i--) strobe(w[i], 1);
      bit_clock = 1'b1; bit_data = w[0];
      tick();
      bit_clock = 1'b0; bit_data = 1'b0;
      checks++; if (sector_done !== 1'b1 || word_valid !== 1'b1) begin failures++; $display("FAIL sector_done_coincident got=%b%b exp=11", sector_done, word_valid); end
      checks++; if (word_index !== 8'd255) begin failures++; $display("FAIL sector_last_index got=%0d exp=255", word_index); end
      repeat (3) tick();
      checks++; if (xfer_cnt - x0 !== 256) begin failures++; $display("FAIL sector_xfers got=%0d exp=256", xfer_cnt - x0); end
      checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL sector_done_count got=%0d exp=1", done_cnt - d0); end
      checks++; if (dut.state_q !== SD_HUNT) begin failures++; $display("FAIL sector_state got=%0d exp=%0d", dut.state_q, SD_HUNT); end
      s0 = start_cnt;
      preamble_sync(16);
      checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL second_sector_start got=%0d exp=1", start_cnt - s0); end
      exp_q.push_back({16'h1234, 8'd0});
      send_word(16'h1234, 1);
      repeat (2) tick();
      en = 1'b0;
      tick();
   endtask

   task automatic test_overrun();
      en = 1'b1;
      tick();
      preamble_sync(16);
      word_ready = 1'b0;
      exp_q.push_back({16'hBEEF, 8'd0});
      send_word(16'hBEEF, 1);
      send_word(16'h0F0F, 1);
      tick();
      checks++; if (word_valid !== 1'b1 || word_out !== 16'hBEEF) begin failures++; $display("FAIL overrun_held got=%b/%h exp=1/beef", word_valid, word_out); end
      checks++; if (word_index !== 8'd0) begin failures++; $display("FAIL overrun_index got=%0d exp=0", word_index); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
      word_ready = 1'b1;
      repeat (2) tick();
      word_ready = 1'b0;
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL overrun_drain got=%b exp=0", word_valid); end
      en = 1'b0;
      tick();
      en = 1'b1;
      tick();
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
      preamble_sync(16);
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_cleared_by_sync got=%b exp=0", overrun); end
      en = 1'b0;
      tick();
   endtask

   task automatic test_lost_clock();
      int x0;
      en = 1'b1;
      word_ready = 1'b1;
      tick();
      preamble_sync(16);
      x0 = xfer_cnt;
      repeat (8) strobe(1'b1, 1);
      repeat (50) tick();
      checks++; if (lost_clock !== 1'b0) begin failures++; $display("FAIL lost_clock_early got=%b exp=0", lost_clock); end
      repeat (20) tick();
      checks++; if (lost_clock !== 1'b1) begin failures++; $display("FAIL lost_clock_set got=%b exp=1", lost_clock); end
      checks++; if (word_valid !== 1'b0 || xfer_cnt !== x0) begin failures++; $display("FAIL lost_clock_partial got=%b/%0d exp=0/%0d", word_valid, xfer_cnt, x0); end
      checks++; if (dut.state_q !== SD_HUNT) begin failures++; $display("FAIL lost_clock_state got=%0d exp=%0d", dut.state_q, SD_HUNT); end
      preamble_sync(16);
      checks++; if (lost_clock !== 1'b0) begin failures++; $display("FAIL lost_clock_cleared got=%b exp=0", lost_clock); end
      exp_q.push_back({16'h5AA5, 8'd0});
      send_word(16'h5AA5, 1);
      repeat (2) tick();
      en = 1'b0;
      tick();
   endtask

   task automatic test_en_drop_and_reset();
      word_ready = 1'b0;
      en = 1'b1;
      tick();
      preamble_sync(16);
      send_word(16'h7E81, 1);
      checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL en_drop_pre_valid got=%b exp=1", word_valid); end
      en = 1'b0;
      tick();
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL en_drop_flush got=%b exp=0", word_valid); end
      checks++; if (dut.state_q !== SD_IDLE) begin failures++; $display("FAIL en_drop_state got=%0d exp=%0d", dut.state_q, SD_IDLE); end
      en = 1'b1;
      tick();
      preamble_sync(16);
      send_word(16'hC00C, 1);
      repeat (4) strobe(1'b1, 1);
      rst = 1'b1;
      tick();
      checks++; if (word_out !== 16'h0 || word_valid !== 1'b0 || word_index !== 8'h0) begin failures++; $display("FAIL rst_mid_data_word got=%h/%b/%0d exp=0/0/0", word_out, word_valid, word_index); end
      checks++; if (sector_start !== 1'b0 || sector_done !== 1'b0 || overrun !== 1'b0 || lost_clock !== 1'b0) begin failures++; $display("FAIL rst_mid_data_flags got=%b%b%b%b exp=0000", sector_start, sector_done, overrun, lost_clock); end
      rst = 1'b0;
      en = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_sync();
      test_full_sector();
      test_overrun();
      test_lost_clock();
      test_en_drop_and_reset();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sector_deserializer.md
# sector_deserializer

Consumes the separated bit stream (one-cycle `wr_clock` strobes with the `wr_data` qualifier) produced by the Hawk data separator, all in the `hf_clk` domain. Hunts for the sector preamble and sync bit, then assembles data bits MSB-first into words. Delivers each word through a one-entry valid/ready buffer to the sector buffer / host interface. Flags sector boundaries, overruns and lost-clock aborts.

## Interface
- `PREAMBLE_MIN`, 16: consecutive 0 bits required before a 1 is accepted as sync
- `WORD_WIDTH`, 16: bits per output word
- `SECTOR_WORDS`, 256: words per sector after sync
- `BIT_TIMEOUT`, 64: `hf_clk` ticks without a bit strobe in DATA before abort
- `hf_clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  block enable; low forces IDLE
- `bit_clock`  in  1  one-cycle strobe, one per bit cell (from separator `wr_clock`)
- `bit_data`  in  1  bit value, sampled only when `bit_clock`=1
- `word_out`  out  WORD_WIDTH  assembled word; stable while `word_valid`=1
- `word_valid`  out  1  buffer holds a word
- `word_ready`  in  1  consumer accepts; transfer when valid&ready
- `word_index`  out  $clog2(SECTOR_WORDS)  index of the word on `word_out`
- `sector_start`  out  1  one-cycle pulse on sync detection
- `sector_done`  out  1  one-cycle pulse when the last word completes assembly
- `overrun`  out  1  sticky; word completed while buffer full and not draining
- `lost_clock`  out  1  sticky; DATA aborted by timeout

## Operation
- States: IDLE, HUNT, DATA.
- IDLE: `en`=0. Counters, shift register and buffer are cleared, and `word_valid`=0. When `en`=1, go to HUNT next cycle.
- HUNT, strobe with 0: zero counter increments and saturates at `PREAMBLE_MIN`.
- HUNT, strobe with 1 and counter=`PREAMBLE_MIN`: this is the sync bit and is not stored. Pulse `sector_start`, clear `overrun` and `lost_clock`, reset bit and word counters, go to DATA.
- HUNT, strobe with 1 and counter<`PREAMBLE_MIN`: zero counter resets to 0.
- DATA, each strobe: shift `bit_data` in at the LSB (first bit ends at the MSB) and increment the bit counter. On bit `WORD_WIDTH`:
  - the word completes and the bit counter wraps to 0;
  - the word counter increments;
  - on word `SECTOR_WORDS`, pulse `sector_done`, clear the zero counter and go to HUNT.
- DATA, timeout: the idle counter resets on every strobe. If it reaches `BIT_TIMEOUT`, set `lost_clock`, discard the partial word, go to HUNT. Words already buffered are kept.
- Buffer, word completes:
  - buffer empty, or full with `word_ready`=1 that cycle: load the word and its index.
  - buffer full with `word_ready`=0: drop the new word and set `overrun`. The held word is kept.
- `en` falling at any point: go to IDLE next cycle and flush the buffer.
- Sticky flags clear only on `rst` or the next sync.

## Timing
- Reset values: `word_out`=0, `word_valid`=0, `word_index`=0, `sector_start`=0, `sector_done`=0, `overrun`=0, `lost_clock`=0; state IDLE.
- Latency: `word_valid` rises 1 cycle after the `bit_clock` carrying the word's last bit.
- `sector_start` is asserted in the cycle after the sync strobe.
- `sector_done` is coincident with the rising `word_valid` of the final word.
- `word_valid` falls the cycle after the valid&ready transfer unless a new word is loaded in the same cycle. Full throughput: one word per `WORD_WIDTH` strobes, no bubbles.
- Strobes arrive at most every 2 `hf_clk` cycles; back-to-back strobes must still be handled.
- The timeout comparison is ≥ `BIT_TIMEOUT` on a `$clog2(BIT_TIMEOUT)+1`-bit counter.

## Structure
- Shared package `hawk_pkg` holds:
  - the state enum `sd_state_t` (IDLE/HUNT/DATA);
  - default constants `HAWK_PREAMBLE_MIN`, `HAWK_SECTOR_WORDS`, `HAWK_WORD_WIDTH`.
- Sub-module `hawk_word_buffer`: one-entry valid/ready holding register, parameterised on data width, with an overrun output.
- The FSM, counters and shift register live in the top module.

## Test plan
- Reset, then `en`=1, 16 zeros, a 1, then 16 data bits 0xA5C3 → `sector_start` once; `word_out`=0xA5C3, `word_index`=0, `word_valid` 1 cycle after the 16th strobe.
- 10 zeros, a 1, then 20 zeros, a 1 → no sync on the first 1; sync on the second.
- Full sector: 256 words, counting 0..255, `word_ready`=1 → 256 transfers; `sector_done` with word 255; state back to HUNT; a second sector syncs.
- `word_ready`=0 across two word completions → first word held, `overrun`=1, second word dropped; a later sync clears `overrun`.
- Strobes stop for 64 cycles after 8 data bits → `lost_clock`=1, no partial word emitted, next preamble + sync resumes at `word_index` 0.
- `en` dropped while `word_valid`=1 → `word_valid`=0 next cycle; state IDLE; `rst` mid-DATA → all outputs 0 next cycle.
